// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with an iterative multiply/divide unit.
//   Single-cycle integer ops produce alu_res combinationally. MULT/MULTU/DIV/DIVU run
//   a WIDTH-step shift-add / restoring-divide sequence on magnitudes, then one sign-fix
//   cycle writes the architectural HI/LO registers.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   data1, data2    - operands A (rs) and B (rt/imm)
//   shamt           - shift amount (shifts act on data2)
//   alu_ctrl        - operation select
//   start           - launches multi-cycle ops; write strobe for MTHI/MTLO
//   alu_res, zero   - combinational result and its zero flag
//   busy, done      - multi-cycle op in progress / one-cycle completion pulse
//   hi, lo          - HI/LO registers
module alu_md #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   data1,
   input  logic [WIDTH-1:0]   data2,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [4:0]         alu_ctrl,
   input  logic               start,
   output logic [WIDTH-1:0]   alu_res,
   output logic               zero,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam logic [4:0] OpSll  = 5'b00000, OpAdd   = 5'b00001, OpSub  = 5'b00010;
   localparam logic [4:0] OpAnd  = 5'b00100, OpOr    = 5'b00101, OpXor  = 5'b00110;
   localparam logic [4:0] OpLui  = 5'b00111, OpNor   = 5'b01000, OpSlt  = 5'b01010;
   localparam logic [4:0] OpSltu = 5'b01011, OpSra   = 5'b01110, OpSrl  = 5'b01111;
   localparam logic [4:0] OpMult = 5'b10000, OpMultu = 5'b10001, OpDiv  = 5'b10010;
   localparam logic [4:0] OpDivu = 5'b10011, OpMfhi  = 5'b10100, OpMflo = 5'b10101;
   localparam logic [4:0] OpMthi = 5'b10110, OpMtlo  = 5'b10111;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

   state_t               state_q;
   logic [SHAMT_W:0]     cnt_q;
   logic [2*WIDTH-1:0]   prod_q;    // mult: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]     b_q;       // |data2|
   logic [WIDTH-1:0]     op1_q;     // raw dividend, returned in HI on divide by zero
   logic                 div_q;
   logic                 neg_q;     // product / quotient must be negated
   logic                 neg_rem_q; // remainder must be negated
   logic                 dbz_q;
   logic                 done_q;
   logic [WIDTH-1:0]     hi_q, lo_q;

   // ---------------- single-cycle ALU ----------------
   always_comb begin
      alu_res = '0;
      case (alu_ctrl)
         OpAdd:   alu_res = data1 + data2;
         OpSub:   alu_res = data1 - data2;
         OpAnd:   alu_res = data1 & data2;
         OpOr:    alu_res = data1 | data2;
         OpXor:   alu_res = data1 ^ data2;
         OpLui:   alu_res = {data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OpNor:   alu_res = ~(data1 | data2);
         OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
         OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, data1 < data2};
         OpSll:   alu_res = data2 << shamt;
         OpSrl:   alu_res = data2 >> shamt;
         OpSra:   alu_res = $signed(data2) >>> shamt;
         OpMfhi:  alu_res = hi_q;
         OpMflo:  alu_res = lo_q;
         default: alu_res = '0;
      endcase
   end

   assign zero = (alu_res == '0);

   // ---------------- iterative datapath ----------------
   logic               is_mul, is_div, is_signed, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
   logic [WIDTH-1:0]   quot, rem;

   always_comb begin
      is_mul    = (alu_ctrl == OpMult) || (alu_ctrl == OpMultu);
      is_div    = (alu_ctrl == OpDiv)  || (alu_ctrl == OpDivu);
      is_signed = (alu_ctrl == OpMult) || (alu_ctrl == OpDiv);
      sa        = is_signed & data1[WIDTH-1];
      sb        = is_signed & data2[WIDTH-1];
      mag_a     = sa ? -data1 : data1;
      mag_b     = sb ? -data2 : data2;

      // Shift-add: add multiplicand to upper half when multiplier LSB is set, shift right.
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, prod_q[WIDTH-1:1]};

      // Restoring divide: shift {rem, quot} left, keep the subtraction if it did not borrow.
      div_sh   = prod_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_sh - {1'b0, b_q};
      div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

      prod_neg = -prod_q;
      quot     = neg_q     ? -prod_q[WIDTH-1:0]       : prod_q[WIDTH-1:0];
      rem      = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         prod_q    <= '0;
         b_q       <= '0;
         op1_q     <= '0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start && (is_mul || is_div)) begin
                  prod_q    <= {{WIDTH{1'b0}}, mag_a};
                  b_q       <= mag_b;
                  op1_q     <= data1;
                  div_q     <= is_div;
                  neg_q     <= sa ^ sb;
                  neg_rem_q <= sa;
                  dbz_q     <= is_div && (data2 == '0);
                  cnt_q     <= '0;
                  state_q   <= StCalc;
               end else if (start && (alu_ctrl == OpMthi)) begin
                  hi_q <= data1;
               end else if (start && (alu_ctrl == OpMtlo)) begin
                  lo_q <= data1;
               end
            end
            StCalc: begin
               prod_q <= div_q ? div_next : mul_next;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == (SHAMT_W + 1)'(WIDTH - 1)) state_q <= StFix;
            end
            StFix: begin
               if (!div_q) begin
                  {hi_q, lo_q} <= neg_q ? prod_neg : prod_q;
               end else if (dbz_q) begin
                  hi_q <= op1_q;
                  lo_q <= '1;
               end else begin
                  hi_q <= rem;
                  lo_q <= quot;
               end
               done_q  <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed self-checking bench for alu_md (WIDTH=32).
module tb_alu_md;

   localparam logic [4:0] OpSll  = 5'b00000, OpAdd   = 5'b00001, OpSub  = 5'b00010;
   localparam logic [4:0] OpAnd  = 5'b00100, OpOr    = 5'b00101, OpXor  = 5'b00110;
   localparam logic [4:0] OpLui  = 5'b00111, OpNor   = 5'b01000, OpSlt  = 5'b01010;
   localparam logic [4:0] OpSltu = 5'b01011, OpSra   = 5'b01110, OpSrl  = 5'b01111;
   localparam logic [4:0] OpMult = 5'b10000, OpMultu = 5'b10001, OpDiv  = 5'b10010;
   localparam logic [4:0] OpDivu = 5'b10011, OpMfhi  = 5'b10100, OpMflo = 5'b10101;
   localparam logic [4:0] OpMthi = 5'b10110, OpMtlo  = 5'b10111;

   logic        clk, rst, start;
   logic [31:0] data1, data2;
   logic [4:0]  shamt, alu_ctrl;
   logic [31:0] alu_res, hi, lo;
   logic        zero, busy, done;

   int n_pass  = 0;
   int n_total = 0;

   alu_md #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .data1(data1), .data2(data2), .shamt(shamt),
      .alu_ctrl(alu_ctrl), .start(start), .alu_res(alu_res), .zero(zero),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Combinational vectors: op, data1, data2, shamt, expected alu_res
   logic [4:0]  c_op  [15] = '{OpAdd, OpSub, OpAnd, OpOr, OpXor, OpLui, OpNor, OpSlt, OpSltu,
                               OpSll, OpSrl, OpSra, 5'b11111, OpMult, OpDivu};
   logic [31:0] c_a   [15] = '{32'hFFFFFFFF, 32'd5, 32'hF0F000FF, 32'hF0F000FF, 32'hF0F000FF,
                               32'h0, 32'h0, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0, 32'd5,
                               32'd3, 32'd9};
   logic [31:0] c_b   [15] = '{32'd2, 32'd5, 32'h0FF00F0F, 32'h0FF00F0F, 32'h0FF00F0F,
                               32'h0000ABCD, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
                               32'h80000000, 32'h80000000, 32'd7, 32'd4, 32'd3};
   logic [4:0]  c_sh  [15] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31,
                               5'd4, 5'd4, 5'd0, 5'd0, 5'd0};
   logic [31:0] c_exp [15] = '{32'h1, 32'h0, 32'h00F0000F, 32'hFFF00FFF, 32'hFF000FF0,
                               32'hABCD0000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h80000000,
                               32'h08000000, 32'hF8000000, 32'h0, 32'h0, 32'h0};

   // Drives a one-cycle start from the current negedge and waits for busy to drop.
   // cyc returns the number of busy cycles seen; the task returns in the done cycle.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
      alu_ctrl = op; data1 = a; data2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_total++;
      if ({hi, lo, busy, done} !== 66'b0) $display("FAIL reset hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_comb;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         alu_ctrl = c_op[i]; data1 = c_a[i]; data2 = c_b[i]; shamt = c_sh[i];
         #1;
         n_total++;
         if (alu_res !== c_exp[i]) $display("FAIL comb[%0d] op=%b got %h want %h", i, c_op[i], alu_res, c_exp[i]);
         else n_pass++;
      end
      alu_ctrl = OpSub; data1 = 32'd5; data2 = 32'd5; #1;
      n_total++;
      if (zero !== 1'b1) $display("FAIL zero_sub got %b want 1", zero);
      else n_pass++;
      alu_ctrl = OpNor; data1 = 32'h0; data2 = 32'h0; #1;
      n_total++;
      if (zero !== 1'b0) $display("FAIL zero_nor got %b want 0", zero);
      else n_pass++;
   endtask

   task automatic test_mult;
      int cyc;
      @(negedge clk);
      run_op(OpMult, 32'hFFFFFFFD, 32'd7, cyc);
      n_total++;
      if (cyc !== 33 || done !== 1'b1) $display("FAIL mult_latency busy=%0d done=%b want 33 1", cyc, done);
      else n_pass++;
      n_total++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) $display("FAIL mult hi=%h lo=%h want ffffffff ffffffeb", hi, lo);
      else n_pass++;
      alu_ctrl = OpMflo; #1;
      n_total++;
      if (alu_res !== 32'hFFFFFFEB || zero !== 1'b0) $display("FAIL mflo got %h z=%b want ffffffeb 0", alu_res, zero);
      else n_pass++;
      alu_ctrl = OpMfhi; #1;
      n_total++;
      if (alu_res !== 32'hFFFFFFFF) $display("FAIL mfhi got %h want ffffffff", alu_res);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (done !== 1'b0) $display("FAIL done_pulse_width done=%b want 0", done);
      else n_pass++;
   endtask

   task automatic test_multu;
      int cyc;
      @(negedge clk);
      run_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
      n_total++;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) $display("FAIL multu hi=%h lo=%h want fffffffe 00000001", hi, lo);
      else n_pass++;
   endtask

   // DIVU followed by DIV launched in DIVU's done cycle.
   task automatic test_back_to_back;
      int cyc;
      @(negedge clk);
      run_op(OpDivu, 32'd100, 32'd7, cyc);
      n_total++;
      if (hi !== 32'd2 || lo !== 32'd14 || done !== 1'b1) $display("FAIL divu hi=%h lo=%h done=%b want 2 e 1", hi, lo, done);
      else n_pass++;
      run_op(OpDiv, 32'hFFFFFFF9, 32'd2, cyc);
      n_total++;
      if (cyc !== 33) $display("FAIL b2b_latency busy=%0d want 33", cyc);
      else n_pass++;
      n_total++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) $display("FAIL div hi=%h lo=%h want ffffffff fffffffd", hi, lo);
      else n_pass++;
   endtask

   task automatic test_div_ovf;
      int cyc;
      @(negedge clk);
      run_op(OpDiv, 32'h80000000, 32'hFFFFFFFF, cyc);
      n_total++;
      if (hi !== 32'h0 || lo !== 32'h80000000) $display("FAIL div_ovf hi=%h lo=%h want 0 80000000", hi, lo);
      else n_pass++;
   endtask

   // DIVU by zero with an ignored second start at cycle 10.
   task automatic test_dbz_restart;
      int n_done, at;
      logic [31:0] h, l;
      n_done = 0; at = 0; h = '0; l = '0;
      @(negedge clk);
      alu_ctrl = OpDivu; data1 = 32'd5; data2 = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin n_done++; at = c; h = hi; l = lo; end
         if (c == 10) begin alu_ctrl = OpMultu; data1 = 32'd3; data2 = 32'd3; start = 1'b1; end
         else start = 1'b0;
         @(negedge clk);
      end
      n_total++;
      if (n_done !== 1 || at !== 34) $display("FAIL dbz_done count=%0d cycle=%0d want 1 34", n_done, at);
      else n_pass++;
      n_total++;
      if (h !== 32'd5 || l !== 32'hFFFFFFFF) $display("FAIL dbz hi=%h lo=%h want 5 ffffffff", h, l);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0 || hi !== 32'd5) $display("FAIL restart_ignored busy=%b hi=%h want 0 5", busy, hi);
      else n_pass++;
   endtask

   task automatic test_mtx;
      @(negedge clk);
      alu_ctrl = OpMthi; data1 = 32'h12345678; start = 1'b1;
      @(negedge clk);
      alu_ctrl = OpMtlo; data1 = 32'h9ABCDEF0;
      @(negedge clk);
      start = 1'b0;
      n_total++;
      if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) $display("FAIL mthi_mtlo hi=%h lo=%h want 12345678 9abcdef0", hi, lo);
      else n_pass++;
   endtask

   task automatic test_rst_mid;
      int n_done;
      n_done = 0;
      @(negedge clk);
      alu_ctrl = OpMult; data1 = 32'd7; data2 = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      n_total++;
      if (busy !== 1'b1) $display("FAIL rst_mid_busy busy=%b want 1", busy);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) $display("FAIL rst_mid busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
      else n_pass++;
      for (int c = 0; c < 40; c++) begin
         if (done) n_done++;
         @(negedge clk);
      end
      n_total++;
      if (n_done !== 0 || lo !== 32'h0) $display("FAIL rst_mid_no_done count=%0d lo=%h want 0 0", n_done, lo);
      else n_pass++;
   endtask

   task automatic test_mthi_busy;
      int k;
      @(negedge clk);
      alu_ctrl = OpMultu; data1 = 32'h00010000; data2 = 32'h00030000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      alu_ctrl = OpMthi; data1 = 32'h1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_total++;
      if (hi !== 32'h0) $display("FAIL mthi_busy hi=%h want 0", hi);
      else n_pass++;
      k = 0;
      while (busy && k < 100) begin k++; @(negedge clk); end
      n_total++;
      if (done !== 1'b1 || hi !== 32'd3 || lo !== 32'h0) $display("FAIL mthi_busy_result done=%b hi=%h lo=%h want 1 3 0", done, hi, lo);
      else n_pass++;
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; start = 1'b0;
      data1 = '0; data2 = '0; shamt = '0; alu_ctrl = '0;
      test_reset();
      test_comb();
      test_mult();
      test_multu();
      test_back_to_back();
      test_div_ovf();
      test_dbz_restart();
      test_mtx();
      test_rst_mid();
      test_mthi_busy();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
